// File: rtl/multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// multicycle_control_fsm
//
// Main control FSM for the multicycle datapath. It steps each instruction
// through FETCH / DECODE / execute / writeback and drives the datapath mux
// selects and write enables for each state.
//
// Memory handshake: the unified memory has a one-sided completion signal.
// While the FSM is in a memory state (FETCH, MEMREAD, MEMWRITE), the access
// request is implied by that state. mem_ready=1 means the access completes
// in this cycle, and the FSM leaves the state on that edge. mem_ready=0
// means the FSM holds the state and keeps the request outputs stable.
//
// Optional feature, selected by the MEM_TIMEOUT_EN macro: an 8-bit wait
// counter bounds each memory wait to TIMEOUT cycles. If a wait runs out, the
// FSM enters FAULT and raises the sticky fault flag until reset. With the
// macro undefined, waits are unbounded and fault is tied to 0.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   op, i_bit, l_bit           instruction-register fields
//   mem_ready                  memory access completes this cycle
//   ir_write, next_pc          latch IR / update PC (FETCH only)
//   adr_src, alu_src_a/b       datapath mux selects
//   alu_op, result_src         ALU decoder mode, result mux select
//   reg_wr, mem_wr, branch     write enables / branch request (gated downstream)
//   inm_src, reg_src           registered extend / register-read selects
//   illegal_op                 pulse while DECODE sees op=3
//   instr_done                 pulse on the last cycle of an instruction
//   fault                      sticky memory-timeout flag
//   state_dbg                  current state encoding, for debug and checkers
// -----------------------------------------------------------------------------
module multicycle_control_fsm #(
  parameter int IMMSRC_W = 2,
  parameter int REGSRC_W = 2,
  parameter int TIMEOUT  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          op,
  input  logic                i_bit,
  input  logic                l_bit,
  input  logic                mem_ready,
  output logic                ir_write,
  output logic                next_pc,
  output logic                adr_src,
  output logic                alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                alu_op,
  output logic [1:0]          result_src,
  output logic                reg_wr,
  output logic                mem_wr,
  output logic                branch,
  output logic [IMMSRC_W-1:0] inm_src,
  output logic [REGSRC_W-1:0] reg_src,
  output logic                illegal_op,
  output logic                instr_done,
  output logic                fault,
  output logic [3:0]          state_dbg
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_FAULT
  } state_t;

  state_t state;

  if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
    $error("multicycle_control_fsm: TIMEOUT must be in 2..255");
  end

`ifdef MEM_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] wait_cnt;
  logic       fault_q;
  logic       in_wait_state;
  assign in_wait_state = (state == S_FETCH) || (state == S_MEMREAD) ||
                         (state == S_MEMWRITE);
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      inm_src <= '0;
      reg_src <= '0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt <= '0;
      fault_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_FETCH:    if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (op)
            2'd0: begin
              state   <= i_bit ? S_EXECUTEI : S_EXECUTER;
              inm_src <= IMMSRC_W'(0);
              reg_src <= REGSRC_W'(0);
            end
            2'd1: begin
              state   <= S_MEMADR;
              inm_src <= IMMSRC_W'(1);
              reg_src <= l_bit ? REGSRC_W'(0) : REGSRC_W'(2);
            end
            2'd2: begin
              state   <= S_BRANCH;
              inm_src <= IMMSRC_W'(2);
              reg_src <= REGSRC_W'(1);
            end
            // Undefined op: drop the instruction and keep the old selects.
            default: state <= S_FETCH;
          endcase
        end
        S_MEMADR:   state <= l_bit ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:    state <= S_FETCH;
        S_MEMWRITE: if (mem_ready) state <= S_FETCH;
        S_EXECUTER: state <= S_ALUWB;
        S_EXECUTEI: state <= S_ALUWB;
        S_ALUWB:    state <= S_FETCH;
        S_BRANCH:   state <= S_FETCH;
        S_FAULT:    state <= S_FAULT;
        default:    state <= S_FETCH;
      endcase
`ifdef MEM_TIMEOUT_EN
      // Waits are only left on mem_ready, so clearing the counter outside a
      // stalled wait state gives a fresh count on every entry.
      if (in_wait_state && !mem_ready) begin
        if (wait_cnt == TO_LAST) begin
          state   <= S_FAULT;
          fault_q <= 1'b1;
        end else begin
          wait_cnt <= wait_cnt + 8'd1;
        end
      end else begin
        wait_cnt <= '0;
      end
`endif
    end
  end

  // Moore decode from state. ir_write, next_pc, illegal_op and the
  // MEMWRITE instr_done also depend on the current inputs.
  always_comb begin
    ir_write   = 1'b0;
    next_pc    = 1'b0;
    adr_src    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 1'b0;
    result_src = 2'd0;
    reg_wr     = 1'b0;
    mem_wr     = 1'b0;
    branch     = 1'b0;
    illegal_op = 1'b0;
    instr_done = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        result_src = 2'd2;
        // mem_ready carries no meaning while reset is asserted.
        ir_write   = mem_ready & rst_n;
        next_pc    = mem_ready & rst_n;
      end
      S_DECODE: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'd2;
        result_src = 2'd2;
        illegal_op = (op == 2'd3);
      end
      S_MEMADR: begin
        alu_src_b = 2'd1;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src = 2'd1;
        reg_wr     = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_wr     = 1'b1;
        instr_done = mem_ready;
      end
      S_EXECUTER: alu_op = 1'b1;
      S_EXECUTEI: begin
        alu_src_b = 2'd1;
        alu_op    = 1'b1;
      end
      S_ALUWB: begin
        reg_wr     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_b  = 2'd1;
        result_src = 2'd2;
        branch     = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// -----------------------------------------------------------------------------
// Testbench for multicycle_control_fsm.
//
// Each instruction is expanded into its cycle-by-cycle expected output
// vectors. The expansion uses the instruction class and the chosen wait
// counts. The resulting stimulus and expectations sit in queues that one
// driver loop then replays against the DUT.
// -----------------------------------------------------------------------------
module tb_multicycle_control_fsm;
  localparam int W       = 19;
  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, mem_ready, i_bit, l_bit;
  logic [1:0] op;
  logic       ir_write, next_pc, adr_src, alu_src_a, alu_op;
  logic [1:0] alu_src_b, result_src, inm_src, reg_src;
  logic       reg_wr, mem_wr, branch, illegal_op, instr_done, fault;
  logic [3:0] state_dbg;

  multicycle_control_fsm #(.IMMSRC_W(2), .REGSRC_W(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .op(op), .i_bit(i_bit), .l_bit(l_bit),
    .mem_ready(mem_ready), .ir_write(ir_write), .next_pc(next_pc),
    .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .reg_wr(reg_wr),
    .mem_wr(mem_wr), .branch(branch), .inm_src(inm_src), .reg_src(reg_src),
    .illegal_op(illegal_op), .instr_done(instr_done), .fault(fault),
    .state_dbg(state_dbg)
  );

  logic [W-1:0] got;
  assign got = {ir_write, next_pc, adr_src, alu_src_a, alu_src_b, alu_op,
                result_src, reg_wr, mem_wr, branch, illegal_op, instr_done,
                fault, inm_src, reg_src};

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  logic [4:0]   stim_q[$];   // {mem_ready, op, i_bit, l_bit}
  string        tag_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  logic [1:0]   m_inm, m_reg;   // model of the selects latched in DECODE

  task automatic check_eq(input string tag, input logic [W-1:0] obs,
                          input logic [W-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] vec(
      input logic irw, input logic npc, input logic adr, input logic a,
      input logic [1:0] b, input logic aop, input logic [1:0] rs,
      input logic rw, input logic mw, input logic br, input logic ill,
      input logic done, input logic flt);
    return {irw, npc, adr, a, b, aop, rs, rw, mw, br, ill, done, flt,
            m_inm, m_reg};
  endfunction

  function automatic logic r1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] r2();
    return 2'($urandom_range(0, 3));
  endfunction

  task automatic push(input logic mr, input logic [1:0] o, input logic ib,
                      input logic lb, input string tag, input logic [W-1:0] e);
    stim_q.push_back({mr, o, ib, lb});
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  // Inputs outside DECODE/MEMADR (and mem_ready outside waits) are random,
  // since the FSM must ignore them there.
  task automatic gen_instr(input logic [1:0] o, input logic ib, input logic lb,
                           input int fw, input int mw);
    for (int k = 0; k < fw; k++)
      push(1'b0, r2(), r1(), r1(), "fetch_wait",
           vec(0, 0, 0, 1, 2'd2, 0, 2'd2, 0, 0, 0, 0, 0, 0));
    push(1'b1, r2(), r1(), r1(), "fetch",
         vec(1, 1, 0, 1, 2'd2, 0, 2'd2, 0, 0, 0, 0, 0, 0));
    push(r1(), o, ib, lb, "decode",
         vec(0, 0, 0, 1, 2'd2, 0, 2'd2, 0, 0, 0, o == 2'd3, 0, 0));
    case (o)
      2'd0: begin m_inm = 2'd0; m_reg = 2'd0; end
      2'd1: begin m_inm = 2'd1; m_reg = lb ? 2'd0 : 2'd2; end
      2'd2: begin m_inm = 2'd2; m_reg = 2'd1; end
      default: ;
    endcase
    case (o)
      2'd0: begin
        push(r1(), r2(), r1(), r1(), ib ? "execute_i" : "execute_r",
             vec(0, 0, 0, 0, ib ? 2'd1 : 2'd0, 1, 2'd0, 0, 0, 0, 0, 0, 0));
        push(r1(), r2(), r1(), r1(), "aluwb",
             vec(0, 0, 0, 0, 2'd0, 0, 2'd0, 1, 0, 0, 0, 1, 0));
      end
      2'd1: begin
        push(r1(), r2(), r1(), lb, "memadr",
             vec(0, 0, 0, 0, 2'd1, 0, 2'd0, 0, 0, 0, 0, 0, 0));
        if (lb) begin
          for (int k = 0; k < mw; k++)
            push(1'b0, r2(), r1(), r1(), "memread_wait",
                 vec(0, 0, 1, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
          push(1'b1, r2(), r1(), r1(), "memread",
               vec(0, 0, 1, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 0));
          push(r1(), r2(), r1(), r1(), "memwb",
               vec(0, 0, 0, 0, 2'd0, 0, 2'd1, 1, 0, 0, 0, 1, 0));
        end else begin
          for (int k = 0; k < mw; k++)
            push(1'b0, r2(), r1(), r1(), "memwrite_wait",
                 vec(0, 0, 1, 0, 2'd0, 0, 2'd0, 0, 1, 0, 0, 0, 0));
          push(1'b1, r2(), r1(), r1(), "memwrite",
               vec(0, 0, 1, 0, 2'd0, 0, 2'd0, 0, 1, 0, 0, 1, 0));
        end
      end
      2'd2:
        push(r1(), r2(), r1(), r1(), "branch",
             vec(0, 0, 0, 0, 2'd1, 0, 2'd2, 0, 0, 1, 0, 1, 0));
      default: ;
    endcase
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1: drive, check at the negedge, then step to the next
  // posedge+1.
  task automatic run_cycles(input int n);
    logic [4:0] s;
    for (int c = 0; c < n && exp_q.size() > 0; c++) begin
      s = stim_q.pop_front();
      {mem_ready, op, i_bit, l_bit} = s;
      @(negedge clk);
      check_eq(tag_q.pop_front(), got, exp_q.pop_front());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    stim_q.delete();
    tag_q.delete();
    m_inm = 2'd0;
    m_reg = 2'd0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [1:0] o;
    rst_n = 1'b0; mem_ready = 1'b1; op = 2'd0; i_bit = 1'b0; l_bit = 1'b0;
    m_inm = 2'd0; m_reg = 2'd0;
    #12;
    check_eq("reset", got, vec(0, 0, 0, 1, 2'd2, 0, 2'd2, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_eq("reset_edge", got, vec(0, 0, 0, 1, 2'd2, 0, 2'd2, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;

    // Directed instructions: data-proc, load with 3 waits, store, branch,
    // undefined op.
    gen_instr(2'd0, 1'b0, 1'b0, 0, 0);
    gen_instr(2'd1, 1'b0, 1'b1, 0, 3);
    gen_instr(2'd1, 1'b0, 1'b0, 1, 2);
    gen_instr(2'd2, 1'b0, 1'b0, 0, 0);
    gen_instr(2'd3, 1'b1, 1'b1, 0, 0);
    gen_instr(2'd0, 1'b1, 1'b0, 2, 0);
    run_cycles(1000);

    // Random instruction mix.
    for (int k = 0; k < 60; k++) begin
      o = r2();
      gen_instr(o, r1(), r1(), $urandom_range(0, 3), $urandom_range(0, 4));
    end
    run_cycles(5000);

    // Reset in the middle of a stalled store: mem_wr must drop at once.
    gen_instr(2'd1, 1'b0, 1'b0, 0, 6);
    run_cycles(4);
    flush_model();
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #2;
    check_eq("mid_reset", got, vec(0, 0, 0, 1, 2'd2, 0, 2'd2, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    check_eq("mid_reset_edge", got, vec(0, 0, 0, 1, 2'd2, 0, 2'd2, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      o = r2();
      gen_instr(o, r1(), r1(), $urandom_range(0, 2), $urandom_range(0, 3));
    end
    run_cycles(5000);

`ifdef MEM_TIMEOUT_EN
    // FETCH stalled for TIMEOUT cycles leads to FAULT, which holds until reset.
    for (int k = 0; k < TIMEOUT; k++)
      push(1'b0, r2(), r1(), r1(), "timeout_wait",
           vec(0, 0, 0, 1, 2'd2, 0, 2'd2, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 5; k++)
      push(r1(), r2(), r1(), r1(), "fault",
           vec(0, 0, 0, 0, 2'd0, 0, 2'd0, 0, 0, 0, 0, 0, 1));
    run_cycles(100);
    flush_model();
    mem_ready = 1'b0;
    rst_n = 1'b0;
    #2;
    check_eq("fault_reset", got, vec(0, 0, 0, 1, 2'd2, 0, 2'd2, 0, 0, 0, 0, 0, 0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
